// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): restoring radix-2, one quotient bit per cycle.
// Optional result cache for DIV+REM pairs is enabled by defining DIV_RESULT_CACHE_EN.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    input  logic            hold,
    output logic            stall_req_ex,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rem, quo, dvs;
    logic             neg_q, neg_r, sel_rem;

    function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v, input logic sgn);
        return (sgn && v < 0) ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    logic            is_signed, go, div_zero, ovf, hit, iter_ge;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] rem_nx, quo_nx, done_q, done_r, hit_q, hit_r;
    logic            done_entry, done_sel;

    assign is_signed = ~op[0];
    assign go        = start & ~flush;
    assign div_zero  = (divisor == '0);
    assign ovf       = is_signed && (dividend == MIN_NEG) && (divisor == '1);

    // The shifted remainder needs XLEN+1 bits; the borrow of the subtract decides the quotient bit.
    assign rem_sh  = {rem, quo[XLEN-1]};
    assign diff    = rem_sh - {1'b0, dvs};
    assign iter_ge = ~diff[XLEN];
    assign rem_nx  = iter_ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nx  = {quo[XLEN-2:0], iter_ge};

`ifdef DIV_RESULT_CACHE_EN
    logic            cache_valid, cache_sgn, op_sgn;
    logic [XLEN-1:0] cache_a, cache_b, cache_q, cache_r, op_a, op_b;

    assign hit   = cache_valid && (dividend == cache_a) && (divisor == cache_b) && (is_signed == cache_sgn);
    assign hit_q = cache_q;
    assign hit_r = cache_r;
`else
    assign hit   = 1'b0;
    assign hit_q = '0;
    assign hit_r = '0;
`endif

    always_comb begin
        state_next = state;
        done_entry = 1'b0;
        done_sel   = sel_rem;
        done_q     = apply_sign(quo_nx, neg_q);
        done_r     = apply_sign(rem_nx, neg_r);
        case (state)
            IDLE: begin
                if (go) begin
                    done_sel = op[1];
                    if (div_zero || ovf || hit) begin
                        state_next = DONE;
                        done_entry = 1'b1;
                    end else begin
                        state_next = CALC;
                    end
                    if (div_zero) begin
                        done_q = '1;
                        done_r = dividend;
                    end else if (ovf) begin
                        done_q = dividend;
                        done_r = '0;
                    end else begin
                        done_q = hit_q;
                        done_r = hit_r;
                    end
                end
            end
            CALC: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                    done_entry = 1'b1;
                end
            end
            DONE: begin
                if (!hold) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            done_entry = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && go) cnt <= CNT_W'(XLEN);
            else if (state == CALC)  cnt <= cnt - CNT_W'(1);
            if (done_entry) result <= done_sel ? done_r : done_q;
        end
    end

    // Datapath registers carry no reset; they are loaded before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && go) begin
            rem     <= '0;
            quo     <= magnitude(dividend, is_signed);
            dvs     <= magnitude(divisor, is_signed);
            neg_q   <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r   <= is_signed & dividend[XLEN-1];
            sel_rem <= op[1];
`ifdef DIV_RESULT_CACHE_EN
            op_a    <= dividend;
            op_b    <= divisor;
            op_sgn  <= is_signed;
`endif
        end else if (state == CALC) begin
            rem <= rem_nx;
            quo <= quo_nx;
        end
    end

`ifdef DIV_RESULT_CACHE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cache_valid <= 1'b0;
        else if (done_entry) cache_valid <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (done_entry) begin
            cache_q   <= done_q;
            cache_r   <= done_r;
            cache_a   <= (state == IDLE) ? dividend : op_a;
            cache_b   <= (state == IDLE) ? divisor : op_b;
            cache_sgn <= (state == IDLE) ? is_signed : op_sgn;
        end
    end
`endif

    assign stall_req_ex = rst_n & start & ~flush & (state != DONE);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner sequences,
// and randomized operations against a plain-arithmetic reference model.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst_n, start, flush, hold;
    logic [1:0]  op;
    logic [31:0] dividend, divisor, result;
    logic        stall_req_ex, busy, result_valid;

    int checks = 0;
    int errors = 0;

`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    localparam int CL = CACHE ? 1 : 33;

    // Model of the last completed operation, used to predict cache hits.
    bit          cache_v = 1'b0;
    logic [31:0] ca, cb;
    bit          cs;

    div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dividend(dividend),
        .divisor(divisor), .flush(flush), .hold(hold), .stall_req_ex(stall_req_ex),
        .busy(busy), .result_valid(result_valid), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // start must stay high while a division is in progress unless flushed.
    always @(negedge clk) begin
        #2;
        if (rst_n && busy && !result_valid && !start && !flush) begin
            errors++;
            $display("FAIL start_drop: start low while dividing, busy=%0b", busy);
        end
    end

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t tbl[19];

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return o[1] ? a : 32'hFFFFFFFF;
        if (!o[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        if (CACHE && cache_v && a == ca && b == cb && bit'(!o[0]) == cs) return 1;
        return 33;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    // Issue one op at the next falling edge (cycle 0); returns in the last DONE cycle with start still high.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int hold_n,
                         output logic [31:0] res, output int lat, output int stalls, output int vcnt);
        @(negedge clk);
        start = 1'b1; op = o; dividend = a; divisor = b; hold = 1'b0; flush = 1'b0;
        lat = -1; stalls = 0; vcnt = 0; res = '0;
        for (int c = 0; c < 45; c++) begin
            #1;
            if (stall_req_ex) stalls++;
            if (result_valid) begin
                lat = c;
                res = result;
                break;
            end
            @(negedge clk);
        end
        if (lat >= 0) begin
            vcnt = 1;
            for (int h = 0; h < hold_n; h++) begin
                hold = 1'b1;
                @(negedge clk);
                #1;
                if (result_valid && result == res && !stall_req_ex) vcnt++;
            end
            hold = 1'b0;
        end
    endtask

    task automatic run(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int lat, st, vc;
        do_op(o, a, b, 0, res, lat, st, vc);
        chk({nm, " result"}, res, exp);
        chk({nm, " latency"}, lat, exp_lat);
        chk({nm, " stall_cycles"}, st, exp_lat);
        cache_v = 1'b1; ca = a; cb = b; cs = !o[0];
    endtask

    initial begin
        logic [31:0] res, pa, pb;
        int lat, st, vc, el;
        bit saw_valid;

        // op: 00 DIV, 01 DIVU, 10 REM, 11 REMU
        tbl[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         33};
        tbl[1]  = '{2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33};
        tbl[2]  = '{2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   CL};
        tbl[3]  = '{2'b01, 32'd5,          32'd0,          32'hFFFFFFFF,   1};
        tbl[4]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1};
        tbl[5]  = '{2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
        tbl[6]  = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1};
        tbl[7]  = '{2'b00, 32'd77,         32'hFFFFFFFB,   32'hFFFFFFF1,   33};
        tbl[8]  = '{2'b10, 32'd77,         32'hFFFFFFFB,   32'd2,          CL};
        tbl[9]  = '{2'b11, 32'd100,        32'd7,          32'd2,          33};
        tbl[10] = '{2'b00, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         33};
        tbl[11] = '{2'b10, 32'd100,        32'hFFFFFFF9,   32'd2,          33};
        tbl[12] = '{2'b01, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33};
        tbl[13] = '{2'b11, 32'hFFFFFFFF,   32'h80000000,   32'h7FFFFFFF,   33};
        tbl[14] = '{2'b01, 32'hFFFFFFFF,   32'h80000000,   32'd1,          CL};
        tbl[15] = '{2'b00, 32'hFFFFFFFD,   32'd0,          32'hFFFFFFFF,   1};
        tbl[16] = '{2'b10, 32'hFFFFFFFD,   32'd0,          32'hFFFFFFFD,   1};
        tbl[17] = '{2'b00, 32'd0,          32'd5,          32'd0,          33};
        tbl[18] = '{2'b01, 32'h80000000,   32'hFFFFFFFF,   32'd0,          33};

        rst_n = 1'b0; start = 1'b1; flush = 1'b0; hold = 1'b0; op = 2'b00;
        dividend = 32'd5; divisor = 32'd3;
        repeat (2) @(negedge clk);
        #1;
        chk("reset stall_req_ex", {31'd0, stall_req_ex}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset result_valid", {31'd0, result_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("idle busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 19; i++)
            run($sformatf("vec%0d", i), tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

        // Flush in the middle of a divide: cycle 10 flushed, IDLE in cycle 11.
        @(negedge clk);
        start = 1'b1; op = 2'b00; dividend = 32'd1000; divisor = 32'd3; saw_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (result_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        chk("flush stall_req_ex", {31'd0, stall_req_ex}, 32'd0);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        chk("flush busy", {31'd0, busy}, 32'd0);
        for (int c = 0; c < 30; c++) begin
            if (result_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        chk("flush never valid", {31'd0, saw_valid}, 32'd0);
        run("after_flush DIV 9/3", 2'b00, 32'd9, 32'd3, 32'd3, model_lat(2'b00, 32'd9, 32'd3));

        // DONE held by downstream stall for 3 cycles, then a back-to-back op.
        el = model_lat(2'b01, 32'd50, 32'd5);
        do_op(2'b01, 32'd50, 32'd5, 3, res, lat, st, vc);
        chk("hold result", res, 32'd10);
        chk("hold latency", lat, el);
        chk("hold valid_cycles", vc, 32'd4);
        cache_v = 1'b1; ca = 32'd50; cb = 32'd5; cs = 1'b0;
        run("b2b DIVU 81/9", 2'b01, 32'd81, 32'd9, 32'd9, model_lat(2'b01, 32'd81, 32'd9));

        // Flush wins over hold in DONE.
        do_op(2'b01, 32'd20, 32'd4, 0, res, lat, st, vc);
        chk("done_flush result", res, 32'd5);
        hold = 1'b1; flush = 1'b1;
        @(negedge clk);
        #1;
        chk("done_flush valid", {31'd0, result_valid}, 32'd0);
        chk("done_flush busy", {31'd0, busy}, 32'd0);
        flush = 1'b0; hold = 1'b0; start = 1'b0;
        @(negedge clk);

        pa = 32'd123; pb = 32'd7;
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            int mode;
            o = 2'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 9));
            a = $urandom;
            b = $urandom;
            case (mode)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = pa; b = pb; end
                3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                4: b = b >> $urandom_range(4, 31);
                5: a = a >> $urandom_range(0, 31);
                default: ;
            endcase
            pa = a; pb = b;
            run($sformatf("rnd%0d", i), o, a, b, ref_div(o, a, b), model_lat(o, a, b));
        end

        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
